// File: rtl/sync_fifo_pkg.sv
// ============================================================================
// Module      : sync_fifo_pkg
// Description : Shared defaults, depth helper and count type for sync_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sync_fifo_pkg;

    localparam int SYNC_FIFO_DSIZE = 8;
    localparam int SYNC_FIFO_ASIZE = 4;

    typedef logic [SYNC_FIFO_ASIZE:0] sync_fifo_cnt_t;

    function automatic int sync_fifo_depth(input int asize);
        return 1 << asize;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_mem.sv
// ============================================================================
// Module      : sync_fifo_mem
// Description : 2**ASIZE x DSIZE register array, sync write, async read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DSIZE = SYNC_FIFO_DSIZE,
    parameter int ASIZE = SYNC_FIFO_ASIZE
) (
    input  logic             clk,
    input  logic             wen,
    input  logic [ASIZE-1:0] waddr,
    input  logic [DSIZE-1:0] wdata,
    input  logic [ASIZE-1:0] raddr,
    output logic [DSIZE-1:0] rdata
);

    localparam int DEPTH = sync_fifo_depth(ASIZE);

    // Storage is deliberately left out of reset.
    logic [DSIZE-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wen) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/sync_fifo.sv
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with count, almost flags, sticky errors.
//               Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DSIZE     = SYNC_FIFO_DSIZE,
    parameter int ASIZE     = SYNC_FIFO_ASIZE,
    parameter int AF_THRESH = sync_fifo_depth(ASIZE) - 2,
    parameter int AE_THRESH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             walmost_full,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             ralmost_empty,
    output logic [ASIZE:0]   count,
    input  logic             clr_err,
    output logic             overflow,
    output logic             underflow
);

    localparam int             DEPTH   = sync_fifo_depth(ASIZE);
    localparam logic [ASIZE:0] C_DEPTH = (ASIZE+1)'(DEPTH);
    localparam logic [ASIZE:0] C_AF    = (ASIZE+1)'(AF_THRESH);
    localparam logic [ASIZE:0] C_AE    = (ASIZE+1)'(AE_THRESH);
    localparam logic [ASIZE:0] C_CNT1  = (ASIZE+1)'(1);
    localparam logic [ASIZE-1:0] C_PTR1 = ASIZE'(1);

    logic [ASIZE-1:0] wptr_q, wptr_d;
    logic [ASIZE-1:0] rptr_q, rptr_d;
    logic [ASIZE:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_acc, rd_acc;
    logic [DSIZE-1:0] mem_rdata;

    assign wfull         = (count_q == C_DEPTH);
    assign rempty        = (count_q == '0);
    assign walmost_full  = (count_q >= C_AF);
    assign ralmost_empty = (count_q <= C_AE);
    assign count         = count_q;
    assign overflow      = overflow_q;
    assign underflow     = underflow_q;

    // Flags come from the registered count, so a same-cycle pop cannot free room.
    assign wr_acc = winc & ~wfull;
    assign rd_acc = rinc & ~rempty;

    always_comb begin
        wptr_d  = wr_acc ? wptr_q + C_PTR1 : wptr_q;
        rptr_d  = rd_acc ? rptr_q + C_PTR1 : rptr_q;
        count_d = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + C_CNT1;
            2'b01:   count_d = count_q - C_CNT1;
            default: count_d = count_q;
        endcase
        // A violation in the same cycle as clr_err keeps the flag set.
        overflow_d  = (winc & wfull)  | (overflow_q  & ~clr_err);
        underflow_d = (rinc & rempty) | (underflow_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    sync_fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk   (clk),
        .wen   (wr_acc),
        .waddr (wptr_q),
        .wdata (wdata),
        .raddr (rptr_q),
        .rdata (mem_rdata)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign rdata = mem_rdata;
`else
    logic [DSIZE-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rd_acc ? mem_rdata : rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;
`endif

endmodule

`default_nettype wire
